// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter fed by a small byte FIFO through a valid/ready handshake.
// The FIFO absorbs CPU store bursts while frames go out at CLK_DIV clocks per bit.
module uart_tx_serializer #(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_tx_valid,
   input  logic [7:0]                    i_tx_data,
   output logic                          o_tx_ready,
   output logic                          o_txd,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      r_state, w_stateNext;
   logic [15:0] r_div, w_divNext;
   logic [2:0]  r_bitIdx, w_bitIdxNext;
   logic [7:0]  r_shift, w_shiftNext;
   logic        r_txd, w_txdNext;

   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wrPtr, r_rdPtr;
   logic [AW:0] w_level;
   logic        w_full, w_empty, w_push, w_pop, w_bitEnd;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   assign w_level  = r_wrPtr - r_rdPtr;
   assign w_empty  = (r_wrPtr == r_rdPtr);
   assign w_full   = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);
   assign w_push   = i_tx_valid && !w_full;
   assign w_bitEnd = (r_div == DIV_LAST);

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wrPtr[AW-1:0]] <= i_tx_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_div    <= '0;
         r_bitIdx <= '0;
         r_shift  <= '0;
         r_txd    <= 1'b1;
      end else begin
         r_state  <= w_stateNext;
         r_div    <= w_divNext;
         r_bitIdx <= w_bitIdxNext;
         r_shift  <= w_shiftNext;
         r_txd    <= w_txdNext;
      end
   end

   // STOP pops the next byte on its final cycle so consecutive frames have no idle gap
   always_comb begin
      w_stateNext  = r_state;
      w_divNext    = r_div;
      w_bitIdxNext = r_bitIdx;
      w_shiftNext  = r_shift;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shiftNext = r_mem[r_rdPtr[AW-1:0]];
               w_divNext   = '0;
               w_stateNext = START;
            end
         end
         START: begin
            if (w_bitEnd) begin
               w_divNext    = '0;
               w_bitIdxNext = '0;
               w_stateNext  = DATA;
            end else begin
               w_divNext = r_div + 16'd1;
            end
         end
         DATA: begin
            if (w_bitEnd) begin
               w_divNext    = '0;
               w_shiftNext  = {1'b0, r_shift[7:1]};
               w_bitIdxNext = r_bitIdx + 3'd1;
               if (r_bitIdx == 3'd7) begin
                  w_stateNext = STOP;
               end
            end else begin
               w_divNext = r_div + 16'd1;
            end
         end
         STOP: begin
            if (w_bitEnd) begin
               w_divNext = '0;
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_shiftNext = r_mem[r_rdPtr[AW-1:0]];
                  w_stateNext = START;
               end else begin
                  w_stateNext = IDLE;
               end
            end else begin
               w_divNext = r_div + 16'd1;
            end
         end
         default: w_stateNext = IDLE;
      endcase

      // Line level is computed from the upcoming state so o_txd can be a flop
      case (w_stateNext)
         START:   w_txdNext = 1'b0;
         DATA:    w_txdNext = w_shiftNext[0];
         default: w_txdNext = 1'b1;
      endcase
   end

   assign o_txd        = r_txd;
   assign o_tx_ready   = !w_full;
   assign o_fifo_level = w_level;
   assign o_busy       = (r_state != IDLE) || (w_level != '0);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a frame-level model predicts pops and
// serial waveforms, and independent monitors decode the line and FIFO status.
module tb_uart_tx_serializer;

   localparam int DIV   = 4;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int FRAME = 10 * DIV;

   typedef struct {
      logic [7:0] data;
      int         startEdge;
   } frame_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          txValid = 1'b0;
   logic [7:0]    txData = 8'h00;
   logic          txReady, txd, busy;
   logic [LW-1:0] level;
   logic          txValid2 = 1'b0;
   logic [7:0]    txData2 = 8'h00;
   logic          txReady2, txd2, busy2;
   logic [LW-1:0] level2;

   int checks = 0;
   int failures = 0;
   int edgeCnt = 0;
   int mdlFrameEnd = 0;
   logic [7:0] mdlFifo [$];
   frame_t     frameQ [$];

   bit               monActive = 1'b0;
   bit               monSkip;
   int               monPos;
   frame_t           monCur;
   logic [FRAME-1:0] monWave, monExp;

   uart_tx_serializer #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clock), .i_rst(reset), .i_tx_valid(txValid), .i_tx_data(txData),
      .o_tx_ready(txReady), .o_txd(txd), .o_busy(busy), .o_fifo_level(level)
   );

   uart_tx_serializer #(.CLK_DIV(2), .FIFO_DEPTH(DEPTH)) dutMin (
      .i_clk(clock), .i_rst(reset), .i_tx_valid(txValid2), .i_tx_data(txData2),
      .o_tx_ready(txReady2), .o_txd(txd2), .o_busy(busy2), .o_fifo_level(level2)
   );

   always #5 clock = ~clock;

   // Expected line level at sample pos of a frame: start 0, data LSB first, stop 1
   function automatic logic expBit(input logic [7:0] d, input int pos);
      int slot;
      slot = pos / DIV;
      if (slot == 0) return 1'b0;
      if (slot >= 9) return 1'b1;
      return d[slot-1];
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d edge=%0d", name, actual, expected, edgeCnt);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d);
      txValid = v;
      txData  = d;
      @(negedge clock);
   endtask

   task automatic waitIdle(input int bound);
      int n;
      n = 0;
      while ((busy || monActive || frameQ.size() != 0 || mdlFifo.size() != 0) && n < bound) begin
         @(negedge clock);
         n++;
      end
      checkOutput("drain_within_bound", (n < bound) ? 1 : 0, 1);
   endtask

   // Reference model: a byte leaves the queue at the first edge where the queue
   // is non-empty and the previous frame's 10 bit slots are over.
   always @(posedge clock) begin
      logic [7:0] b;
      bit         pushNow, popNow;
      edgeCnt++;
      if (reset) begin
         mdlFifo.delete();
         frameQ.delete();
         mdlFrameEnd = 0;
      end else begin
         pushNow = txValid && (mdlFifo.size() < DEPTH);
         popNow  = (mdlFifo.size() > 0) && (edgeCnt >= mdlFrameEnd);
         if (popNow) begin
            b = mdlFifo.pop_front();
            frameQ.push_back('{data: b, startEdge: edgeCnt});
            mdlFrameEnd = edgeCnt + FRAME;
         end
         if (pushNow) mdlFifo.push_back(txData);
      end
   end

   // Status monitor: FIFO level, ready, busy and idle line against the model
   always @(negedge clock) begin
      bit frameOn;
      if (!reset) begin
         frameOn = (edgeCnt < mdlFrameEnd);
         checkOutput("fifo_level", int'(level), mdlFifo.size());
         checkOutput("tx_ready", int'(txReady), (mdlFifo.size() < DEPTH) ? 1 : 0);
         checkOutput("busy", int'(busy), (frameOn || mdlFifo.size() > 0) ? 1 : 0);
         if (!frameOn) checkOutput("idle_txd", int'(txd), 1);
      end
   end

   // Line monitor: detects each start bit, pops the expected frame, captures it
   always @(negedge clock) begin
      if (reset) begin
         monActive = 1'b0;
      end else begin
         if (!monActive && txd == 1'b0) begin
            monActive = 1'b1;
            monPos    = 0;
            monSkip   = 1'b0;
            monWave   = '0;
            if (frameQ.size() == 0) begin
               monSkip = 1'b1;
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_frame actual=start_bit expected=idle edge=%0d", edgeCnt);
            end else begin
               monCur = frameQ.pop_front();
               for (int p = 0; p < FRAME; p++) monExp[p] = expBit(monCur.data, p);
               checkOutput("frame_start_edge", edgeCnt, monCur.startEdge);
            end
         end else if (monActive) begin
            monPos++;
         end
         if (monActive) begin
            monWave[monPos] = txd;
            if (monPos == FRAME - 1) begin
               if (!monSkip) begin
                  checks++;
                  if (monWave !== monExp) begin
                     failures++;
                     $display("[TB] FAIL frame_%02h actual=%h expected=%h", monCur.data, monWave, monExp);
                  end
               end
               monActive = 1'b0;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] start");
      repeat (3) @(negedge clock);
      checkOutput("reset_txd", int'(txd), 1);
      checkOutput("reset_ready", int'(txReady), 1);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_level", int'(level), 0);
      reset = 1'b0;
      repeat (5) applyStimulus(1'b0, 8'h00);

      $display("[TB] single byte 0x55");
      applyStimulus(1'b1, 8'h55);
      applyStimulus(1'b0, 8'h00);
      waitIdle(100);

      $display("[TB] back-to-back 0xA5 0x3C");
      applyStimulus(1'b1, 8'hA5);
      applyStimulus(1'b1, 8'h3C);
      applyStimulus(1'b0, 8'h00);
      waitIdle(200);

      $display("[TB] overflow then full/pop collision");
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i + 16));
      for (int i = 0; i < 50; i++) applyStimulus(1'b1, 8'(i + 64));
      applyStimulus(1'b0, 8'h00);
      waitIdle(20 * FRAME);

      $display("[TB] random traffic");
      for (int i = 0; i < 250; i++) applyStimulus($urandom_range(0, 3) == 0, 8'($urandom));
      applyStimulus(1'b0, 8'h00);
      waitIdle(20 * FRAME);

      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b0, 8'h00);
      repeat (8) @(negedge clock);
      #2 reset = 1'b1;
      #1 checkOutput("reset_async_txd", int'(txd), 1);
      repeat (3) begin
         @(negedge clock);
         checkOutput("reset_hold_txd", int'(txd), 1);
         checkOutput("reset_hold_ready", int'(txReady), 1);
         checkOutput("reset_hold_busy", int'(busy), 0);
         checkOutput("reset_hold_level", int'(level), 0);
      end
      reset = 1'b0;
      repeat (60) applyStimulus(1'b0, 8'h00);

      $display("[TB] minimum divider 0xFF");
      txValid2 = 1'b1;
      txData2  = 8'hFF;
      @(negedge clock);
      txValid2 = 1'b0;
      checkOutput("min_level_after_push", int'(level2), 1);
      for (int k = 1; k <= 21; k++) begin
         @(negedge clock);
         checkOutput($sformatf("min_txd_k%0d", k), int'(txd2), (k <= 2) ? 0 : 1);
         checkOutput($sformatf("min_busy_k%0d", k), int'(busy2), (k <= 20) ? 1 : 0);
         if (k == 1) checkOutput("min_level_after_pop", int'(level2), 0);
      end
      checkOutput("min_ready", int'(txReady2), 1);

      waitIdle(100);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
